// File: rtl/status_flag_unit.sv
// Architectural N/V/Z/C status register with a flag-save LIFO for interrupt
// entry/return and a registered branch-condition evaluator.
module status_flag_unit #(
   parameter int STACK_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] condition_values,
   input  logic       flag_we,
   input  logic [3:0] flag_mask,
   input  logic       push,
   input  logic       pop,
   input  logic       eval,
   input  logic [3:0] cond_sel,
   output logic [3:0] flags,
   output logic       branch_taken,
   output logic       branch_valid,
   output logic       stack_empty,
   output logic       stack_full,
   output logic       stack_err
);

   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] CNT_DEPTH = CW'(STACK_DEPTH);

   // Branch condition codes evaluated against f = {N, V, Z, C}.
   function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] sel);
      logic n, v, z, c;
      n = f[3];
      v = f[2];
      z = f[1];
      c = f[0];
      case (sel)
         4'd0:    cond_eval = z;
         4'd1:    cond_eval = !z;
         4'd2:    cond_eval = c;
         4'd3:    cond_eval = !c;
         4'd4:    cond_eval = n;
         4'd5:    cond_eval = !n;
         4'd6:    cond_eval = v;
         4'd7:    cond_eval = !v;
         4'd8:    cond_eval = c & !z;
         4'd9:    cond_eval = !c | z;
         4'd10:   cond_eval = (n == v);
         4'd11:   cond_eval = (n != v);
         4'd12:   cond_eval = !z & (n == v);
         4'd13:   cond_eval = z | (n != v);
         4'd14:   cond_eval = 1'b1;
         4'd15:   cond_eval = 1'b0;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   logic [3:0]    flags_r;
   logic [3:0]    stack_r [STACK_DEPTH];
   logic [CW-1:0] count_r;
   logic          branch_taken_r;
   logic          branch_valid_r;
   logic          stack_empty_r;
   logic          stack_full_r;
   logic          stack_err_r;

   logic          push_ok_s;
   logic          pop_ok_s;
   logic          stack_err_s;
   logic [CW-1:0] pop_cnt_s;
   logic [IW-1:0] push_idx_s;
   logic [IW-1:0] pop_idx_s;
   logic [3:0]    flags_nxt_s;
   logic [CW-1:0] count_nxt_s;

   // Legality of stack requests; push+pop together is always illegal.
   always_comb begin
      push_ok_s   = push & !pop & (count_r < CNT_DEPTH);
      pop_ok_s    = pop & !push & (count_r != CNT_ZERO);
      stack_err_s = (push | pop) & !push_ok_s & !pop_ok_s;
      pop_cnt_s   = count_r - CNT_ONE;
      push_idx_s  = count_r[IW-1:0];
      pop_idx_s   = pop_cnt_s[IW-1:0];
   end

   // Next flags and count; a legal pop overrides a same-cycle flag write.
   always_comb begin
      flags_nxt_s = flags_r;
      count_nxt_s = count_r;
      if (pop_ok_s) begin
         flags_nxt_s = stack_r[pop_idx_s];
      end else if (flag_we) begin
         flags_nxt_s = (flag_mask & condition_values) | (~flag_mask & flags_r);
      end else begin
         flags_nxt_s = flags_r;
      end
      if (push_ok_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (pop_ok_s) begin
         count_nxt_s = pop_cnt_s;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Stack storage holds pre-update flags; entries need no reset.
   always_ff @(posedge clk) begin
      if (!reset && push_ok_s) begin
         stack_r[push_idx_s] <= flags_r;
      end
   end

   // Architectural state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_r        <= 4'b0000;
         count_r        <= CNT_ZERO;
         branch_taken_r <= 1'b0;
         branch_valid_r <= 1'b0;
         stack_empty_r  <= 1'b1;
         stack_full_r   <= 1'b0;
         stack_err_r    <= 1'b0;
      end else begin
         flags_r        <= flags_nxt_s;
         count_r        <= count_nxt_s;
         branch_valid_r <= eval;
         stack_empty_r  <= (count_nxt_s == CNT_ZERO);
         stack_full_r   <= (count_nxt_s == CNT_DEPTH);
         stack_err_r    <= stack_err_s;
         if (eval) begin
            branch_taken_r <= cond_eval(flags_r, cond_sel);
         end else begin
            branch_taken_r <= branch_taken_r;
         end
      end
   end

   assign flags        = flags_r;
   assign branch_taken = branch_taken_r;
   assign branch_valid = branch_valid_r;
   assign stack_empty  = stack_empty_r;
   assign stack_full   = stack_full_r;
   assign stack_err    = stack_err_r;

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Architectural status register and branch-condition evaluator for the multi-cycle CPU. Sits directly downstream of the status detection stage: it latches the 4-bit condition vector {sign, overflow, zero, carry} under per-flag write masks and saves/restores flags on a small LIFO for interrupt entry/return. It evaluates the 16 branch condition codes against the latched flags and returns a registered taken/not-taken result to the control FSM.

## Interface
Parameters:
- STACK_DEPTH, 4, number of flag-save entries (≥1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- condition_values  input  4  from status detection: [0]=C, [1]=Z, [2]=V, [3]=N
- flag_we  input  1  latch condition_values into flags this cycle
- flag_mask  input  4  per-bit update enable (same bit order); bit=0 keeps old flag
- push  input  1  save current flags onto stack
- pop  input  1  restore flags from top of stack
- eval  input  1  request branch evaluation
- cond_sel  input  4  condition code for eval
- flags  output  4  current flag register, same bit order as condition_values
- branch_taken  output  1  result of last eval, registered
- branch_valid  output  1  one-cycle pulse, branch_taken is valid
- stack_empty  output  1  stack holds 0 entries
- stack_full  output  1  stack holds STACK_DEPTH entries
- stack_err  output  1  one-cycle pulse on illegal stack request

## Operation
- Reset values: flags=4'b0000, branch_taken=0, branch_valid=0, stack_err=0, stack count=0 (stack_empty=1, stack_full=0). Stack entry contents are don't-care.
- Flag update, when flag_we=1 and no legal pop: flags[i] <= flag_mask[i] ? condition_values[i] : flags[i].
- Push is legal when count < STACK_DEPTH. It writes the pre-update flags (register value before this edge) at index count, then count+1. A simultaneous flag_we still applies to flags.
- Pop is legal when count > 0. It sets flags <= entry[count-1], then count-1. A legal pop has priority over flag_we, which is ignored that cycle.
- Illegal requests pulse stack_err for one cycle and leave the stack and count unchanged:
  - push when full
  - pop when empty
  - push and pop in the same cycle
- In all three illegal cases, flag_we behaves as if no pop were requested.
- Condition codes, where N=flags[3], V=flags[2], Z=flags[1], C=flags[0]:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Eval uses the flag register value before the current edge. There is no bypass from condition_values or from a same-cycle write/pop.
- branch_taken holds its last value until the next eval.

## Timing
- flags updates on the edge where flag_we/pop is sampled, so the new value is visible the next cycle.
- eval sampled at edge k → branch_valid=1 and branch_taken set during cycle k+1. Back-to-back evals give back-to-back valid pulses.
- stack_empty and stack_full are derived from count and reflect the count after the edge.
- stack_err asserts in the cycle after the offending request, for one cycle.
- Reset asserted mid-operation overrides every request that cycle. All outputs take reset values the next cycle, and a pending branch_valid is dropped.

## Test plan
- Reset, then flag_we=1, mask=4'hF, cv=4'b1010 → next cycle flags=4'b1010. Then mask=4'b0001, cv=4'b0101 → flags=4'b1011.
- flags=4'b1000 (N=1, V=0). Eval 10 (GE) → taken=0; eval 11 (LT) → taken=1; eval 14 → taken=1; eval 15 → taken=0. Each result appears one cycle after its eval with a valid pulse.
- Same cycle: eval EQ with Z=0 in the register, flag_we setting Z=1 → branch_taken=0 (no bypass). flags=4'b0010 afterwards.
- STACK_DEPTH=4: push flag patterns 1,2,3,4 → stack_full=1; 5th push → stack_err pulse, count stays 4. Then pop ×4 → flags 4,3,2,1 in order, stack_empty=1; 5th pop → stack_err, flags unchanged.
- Push with flag_we in the same cycle: stack gets the old flags, register gets the new flags. Pop with flag_we in the same cycle: popped value wins. Push and pop in the same cycle: stack_err pulse, count unchanged.
- Mid-sequence reset with count=2 and eval pending → next cycle flags=0, count=0, branch_valid=0, stack_err=0.
